// File: rtl/wdt_pet_gen.sv
// -----------------------------------------------------------------------------
// wdt_pet_gen
// Petting side of the watchdog interface. It pulses wdt_pet once per pet
// window, but only when the monitored logic delivered a heartbeat in that
// window. It counts consecutive heartbeat-less windows and watchdog expiries,
// and latches a sticky escalate fault that only resetn clears.
//
// Ports
//   clk        in   1  clock (100 MHz domain, beside wdt)
//   resetn     in   1  synchronous active-low reset
//   enable     in   1  level; 1 = run pet generation
//   heartbeat  in   1  single-cycle liveness pulse
//   wdt_irq    in   1  watchdog expiry level; rising edge detected here
//   wdt_pet    out  1  pet pulse to wdt (registered)
//   escalate   out  1  sticky fault flag (registered)
//   active     out  1  1 while in WAIT or PET (registered)
//   miss_cnt   out  8  consecutive missed windows (registered)
//   irq_cnt    out  8  wdt_irq rising edges, saturating at 255 (registered)
// -----------------------------------------------------------------------------
module wdt_pet_gen #(
  parameter int unsigned CLK_PERIOD_NS    = 10,
  parameter int unsigned PET_PERIOD_NS    = 500000000,
  parameter int unsigned PET_PULSE_CYCLES = 4,
  parameter int unsigned MAX_MISSES       = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       heartbeat,
  input  logic       wdt_irq,
  output logic       wdt_pet,
  output logic       escalate,
  output logic       active,
  output logic [7:0] miss_cnt,
  output logic [7:0] irq_cnt
);

  localparam int unsigned PERIOD_CYC = PET_PERIOD_NS / CLK_PERIOD_NS;
  localparam int unsigned WCNT_W     = (PERIOD_CYC > 32'd1) ? $clog2(PERIOD_CYC) : 32'd1;
  localparam int unsigned PCNT_W     = $clog2(PET_PULSE_CYCLES + 32'd1);

  localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(32'd1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PERIOD_CYC - 32'd1);
  localparam logic [PCNT_W-1:0] PCNT_ZERO = {PCNT_W{1'b0}};
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(32'd1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PET_PULSE_CYCLES - 32'd1);
  localparam logic [7:0]        MISS_LIM  = 8'(MAX_MISSES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PET   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e            state_q,   state_d;
  logic [WCNT_W-1:0] wcnt_q,    wcnt_d;
  logic [PCNT_W-1:0] pcnt_q,    pcnt_d;
  logic              hb_seen_q, hb_seen_d;
  logic [7:0]        miss_q,    miss_d;
  logic [7:0]        irqc_q,    irqc_d;
  logic              irq_prev_q;
  logic              pet_q,     pet_d;
  logic              esc_q,     esc_d;
  logic              act_q,     act_d;

  logic              irq_edge_s;
  logic              hb_any_s;
  logic [7:0]        miss_inc_s;

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    pcnt_d     = pcnt_q;
    hb_seen_d  = hb_seen_q;
    miss_d     = miss_q;
    irqc_d     = irqc_q;
    irq_edge_s = wdt_irq & ~irq_prev_q;
    // A heartbeat in the window-end cycle still belongs to the ending window.
    hb_any_s   = hb_seen_q | heartbeat;
    miss_inc_s = miss_q + 8'd1;

    if (irq_edge_s && (irqc_q != 8'hFF)) begin
      irqc_d = irqc_q + 8'd1;
    end else begin
      irqc_d = irqc_q;
    end

    case (state_q)
      ST_IDLE: begin
        wcnt_d    = WCNT_ZERO;
        pcnt_d    = PCNT_ZERO;
        hb_seen_d = 1'b0;
        // An irq edge in IDLE is only counted, never a fault.
        if (enable) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT, ST_PET: begin
        if (irq_edge_s) begin
          state_d = ST_FAULT;
        end else if (!enable) begin
          state_d   = ST_IDLE;
          wcnt_d    = WCNT_ZERO;
          pcnt_d    = PCNT_ZERO;
          hb_seen_d = 1'b0;
          miss_d    = 8'd0;
        end else begin
          hb_seen_d = hb_any_s;
          // The pulse overlaps the start of the next window; wcnt keeps running.
          if (state_q == ST_PET) begin
            if (pcnt_q == PCNT_LAST) begin
              state_d = ST_WAIT;
              pcnt_d  = PCNT_ZERO;
            end else begin
              pcnt_d  = pcnt_q + PCNT_ONE;
            end
          end else begin
            pcnt_d = PCNT_ZERO;
          end
          if (wcnt_q == WCNT_LAST) begin
            wcnt_d    = WCNT_ZERO;
            hb_seen_d = 1'b0;
            if (hb_any_s) begin
              state_d = ST_PET;
              pcnt_d  = PCNT_ZERO;
              miss_d  = 8'd0;
            end else if (miss_inc_s == MISS_LIM) begin
              state_d = ST_FAULT;
              miss_d  = miss_inc_s;
            end else begin
              miss_d  = miss_inc_s;
            end
          end else begin
            wcnt_d = wcnt_q + WCNT_ONE;
          end
        end
      end

      ST_FAULT: begin
        state_d   = ST_FAULT;
        wcnt_d    = WCNT_ZERO;
        pcnt_d    = PCNT_ZERO;
        hb_seen_d = 1'b0;
      end

      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // Outputs are registered from the next state so they track the transition
    // taken on the same edge.
    pet_d = (state_d == ST_PET);
    esc_d = (state_d == ST_FAULT);
    act_d = (state_d == ST_WAIT) || (state_d == ST_PET);
  end

  // State, counters, irq edge history and outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= WCNT_ZERO;
      pcnt_q     <= PCNT_ZERO;
      hb_seen_q  <= 1'b0;
      miss_q     <= 8'd0;
      irqc_q     <= 8'd0;
      // Cleared so an irq already high when reset releases counts as an edge.
      irq_prev_q <= 1'b0;
      pet_q      <= 1'b0;
      esc_q      <= 1'b0;
      act_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      pcnt_q     <= pcnt_d;
      hb_seen_q  <= hb_seen_d;
      miss_q     <= miss_d;
      irqc_q     <= irqc_d;
      irq_prev_q <= wdt_irq;
      pet_q      <= pet_d;
      esc_q      <= esc_d;
      act_q      <= act_d;
    end
  end

  assign wdt_pet  = pet_q;
  assign escalate = esc_q;
  assign active   = act_q;
  assign miss_cnt = miss_q;
  assign irq_cnt  = irqc_q;

endmodule

// File: tb/tb_wdt_pet_gen.sv
// -----------------------------------------------------------------------------
// tb_wdt_pet_gen
// Directed bench for wdt_pet_gen with PERIOD_CYC=10, PET_PULSE_CYCLES=2,
// MAX_MISSES=3. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, so each sample shows the edge just taken.
// -----------------------------------------------------------------------------
module tb_wdt_pet_gen;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       heartbeat;
  logic       wdt_irq;
  logic       wdt_pet;
  logic       escalate;
  logic       active;
  logic [7:0] miss_cnt;
  logic [7:0] irq_cnt;

  int tests = 0;
  int fails = 0;

  // 100 MHz clock
  always #5 clk = ~clk;

  wdt_pet_gen #(
    .CLK_PERIOD_NS   (10),
    .PET_PERIOD_NS   (100),
    .PET_PULSE_CYCLES(2),
    .MAX_MISSES      (3)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .heartbeat(heartbeat),
    .wdt_irq  (wdt_irq),
    .wdt_pet  (wdt_pet),
    .escalate (escalate),
    .active   (active),
    .miss_cnt (miss_cnt),
    .irq_cnt  (irq_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic pet, input logic esc,
                         input logic act, input logic [7:0] miss, input logic [7:0] irqc);
    chk1({tag, ".pet"},    wdt_pet,  pet);
    chk1({tag, ".esc"},    escalate, esc);
    chk1({tag, ".active"}, active,   act);
    chk8({tag, ".miss"},   miss_cnt, miss);
    chk8({tag, ".irq"},    irq_cnt,  irqc);
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    enable    = 1'b0;
    heartbeat = 1'b0;
    wdt_irq   = 1'b0;
    step();
    resetn    = 1'b1;
  endtask

  // Directed stimulus sequence
  initial begin
    resetn    = 1'b0;
    enable    = 1'b0;
    heartbeat = 1'b0;
    wdt_irq   = 1'b0;
    step();
    step();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // 1: heartbeat at window cycle 3 -> pets on cycles 11-12, 21-22, 31-32
    resetn = 1'b1;
    enable = 1'b1;
    step();
    chk1("t1.active", active, 1'b1);
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 10; c++) begin
        heartbeat = (c == 3);
        chk1($sformatf("t1.pet.w%0d.c%0d", w, c), wdt_pet, (w >= 1) && (c <= 1));
        step();
      end
    end
    heartbeat = 1'b0;
    chk_all("t1.c31", 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);
    step();
    chk1("t1.c32.pet", wdt_pet, 1'b1);
    step();
    chk1("t1.c33.pet", wdt_pet, 1'b0);

    // 2: no heartbeat -> miss 1, 2, then FAULT; enable toggling has no effect
    do_reset();
    enable = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      repeat (10) begin
        chk1("t2.pet", wdt_pet, 1'b0);
        step();
      end
      chk8($sformatf("t2.miss%0d", k), miss_cnt, 8'(k));
      chk1($sformatf("t2.esc%0d", k), escalate, (k == 3));
      chk1($sformatf("t2.active%0d", k), active, (k != 3));
    end
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    chk_all("t2.toggle", 1'b0, 1'b1, 1'b0, 8'd3, 8'd0);
    repeat (15) step();
    chk1("t2.late.pet", wdt_pet, 1'b0);
    chk1("t2.late.esc", escalate, 1'b1);

    // 3: heartbeat on last window cycle, one missed window, then recovery
    do_reset();
    enable = 1'b1;
    step();
    repeat (9) step();
    heartbeat = 1'b1;
    chk1("t3.w1end.pet", wdt_pet, 1'b0);
    step();
    heartbeat = 1'b0;
    chk1("t3.pet1", wdt_pet, 1'b1);
    chk8("t3.miss.a", miss_cnt, 8'd0);
    step();
    chk1("t3.pet2", wdt_pet, 1'b1);
    step();
    chk1("t3.pet3", wdt_pet, 1'b0);
    repeat (8) step();
    chk8("t3.miss.b", miss_cnt, 8'd1);
    chk1("t3.nopet", wdt_pet, 1'b0);
    repeat (9) step();
    heartbeat = 1'b1;
    step();
    heartbeat = 1'b0;
    chk_all("t3.resume", 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);

    // 4: irq rises during first pet cycle, held for 5 cycles
    do_reset();
    enable = 1'b1;
    step();
    repeat (3) step();
    heartbeat = 1'b1;
    step();
    heartbeat = 1'b0;
    repeat (6) step();
    chk1("t4.pet", wdt_pet, 1'b1);
    wdt_irq = 1'b1;
    step();
    chk_all("t4.fault", 1'b0, 1'b1, 1'b0, 8'd0, 8'd1);
    repeat (4) begin
      step();
      chk8("t4.irq.held", irq_cnt, 8'd1);
    end
    wdt_irq = 1'b0;
    step();

    // 5: disable mid-window clears misses; re-enable gives a fresh window
    do_reset();
    enable = 1'b1;
    step();
    repeat (20) step();
    chk8("t5.miss2", miss_cnt, 8'd2);
    repeat (5) step();
    chk1("t5.active.before", active, 1'b1);
    enable = 1'b0;
    step();
    chk_all("t5.disabled", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    enable = 1'b1;
    step();
    chk1("t5.reenabled", active, 1'b1);
    repeat (9) step();
    chk1("t5.w9.pet", wdt_pet, 1'b0);
    heartbeat = 1'b1;
    step();
    heartbeat = 1'b0;
    chk1("t5.fresh.pet", wdt_pet, 1'b1);
    wdt_irq = 1'b1;
    step();
    wdt_irq = 1'b0;
    chk1("t5.fault.esc", escalate, 1'b1);
    chk8("t5.fault.irq", irq_cnt, 8'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk_all("t5.reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // 6: irq high across reset release counts; pulses in IDLE saturate at 255
    enable  = 1'b0;
    resetn  = 1'b0;
    wdt_irq = 1'b1;
    step();
    resetn = 1'b1;
    step();
    chk8("t6.release.irq", irq_cnt, 8'd1);
    chk1("t6.release.esc", escalate, 1'b0);
    wdt_irq = 1'b0;
    step();
    repeat (253) begin
      wdt_irq = 1'b1;
      step();
      wdt_irq = 1'b0;
      step();
    end
    chk8("t6.irq254", irq_cnt, 8'd254);
    repeat (47) begin
      wdt_irq = 1'b1;
      step();
      wdt_irq = 1'b0;
      step();
    end
    chk_all("t6.sat", 1'b0, 1'b0, 1'b0, 8'd0, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
